// File: rtl/reorder_buffer_pkg.sv
// -----------------------------------------------------------------------------
// reorder_buffer_pkg : shared sizes and entry types for the reorder buffer
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package reorder_buffer_pkg;

  localparam int ROB_ENTRIES  = 18;
  localparam int ROB_IDX_BITS = 5;
  localparam int GPR_BITS     = 64;
  localparam int GPR_IDX_BITS = 5;
  localparam int NZCV_BITS    = 4;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  typedef struct packed {
    logic [GPR_IDX_BITS-1:0] gpr_index;
    logic                    writes_gpr;
    logic                    set_nzcv;
    logic [GPR_BITS-1:0]     value;
    nzcv_t                   nzcv;
  } rob_entry_t;

endpackage

`default_nettype wire

// File: rtl/reorder_buffer_ptr_inc.sv
// -----------------------------------------------------------------------------
// rob_ptr_inc : modular pointer increment for a non-power-of-two ring
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module rob_ptr_inc #(
  parameter int SIZE = 18,
  parameter int W    = 5
) (
  input  logic [W-1:0] ptr_in,
  output logic [W-1:0] ptr_next_out
);

  localparam logic [W-1:0] LAST = W'(SIZE - 1);

  // Explicit wrap compare: SIZE need not be a power of two.
  assign ptr_next_out = (ptr_in == LAST) ? '0 : ptr_in + W'(1);

endmodule

`default_nettype wire

// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer : circular ROB, in-order allocate/retire, out-of-order writeback
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_SIZE = ROB_ENTRIES,
  parameter int IDX_W    = ROB_IDX_BITS,
  parameter int VAL_W    = GPR_BITS
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    flush_in,
  input  logic                    alloc_valid_in,
  input  logic [GPR_IDX_BITS-1:0] alloc_gpr_index_in,
  input  logic                    alloc_writes_gpr_in,
  input  logic                    alloc_set_nzcv_in,
  output logic [IDX_W-1:0]        alloc_rob_index_out,
  output logic                    full_out,
  input  logic                    wb_valid_in,
  input  logic [IDX_W-1:0]        wb_rob_index_in,
  input  logic [VAL_W-1:0]        wb_value_in,
  input  nzcv_t                   wb_nzcv_in,
  input  logic [IDX_W-1:0]        lookup_a_idx_in,
  input  logic [IDX_W-1:0]        lookup_b_idx_in,
  output logic                    lookup_a_valid_out,
  output logic                    lookup_b_valid_out,
  output logic [VAL_W-1:0]        lookup_a_value_out,
  output logic [VAL_W-1:0]        lookup_b_value_out,
  output logic                    commit_valid_out,
  output logic [GPR_IDX_BITS-1:0] commit_gpr_index_out,
  output logic                    commit_writes_gpr_out,
  output logic [VAL_W-1:0]        commit_value_out,
  output logic                    commit_set_nzcv_out,
  output nzcv_t                   commit_nzcv_out,
  output logic [IDX_W-1:0]        commit_rob_index_out
);

  localparam int                CNT_W    = $clog2(ROB_SIZE + 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(ROB_SIZE);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(ROB_SIZE - 1);

  rob_entry_t          entry_q [ROB_SIZE];
  rob_entry_t          entry_d [ROB_SIZE];
  logic [ROB_SIZE-1:0] busy_q, busy_d, done_q, done_d;
  logic [IDX_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [IDX_W-1:0]    head_next, tail_next;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                commit_valid_q, commit_valid_d;
  rob_entry_t          commit_q, commit_d;
  logic [IDX_W-1:0]    commit_idx_q, commit_idx_d;
  logic                alloc_ok, commit_fire, wb_hit;

  rob_ptr_inc #(.SIZE(ROB_SIZE), .W(IDX_W)) u_head_inc (
    .ptr_in       (head_q),
    .ptr_next_out (head_next)
  );

  rob_ptr_inc #(.SIZE(ROB_SIZE), .W(IDX_W)) u_tail_inc (
    .ptr_in       (tail_q),
    .ptr_next_out (tail_next)
  );

  assign full_out            = (count_q == FULL_CNT);
  assign alloc_rob_index_out = tail_q;
  assign alloc_ok            = alloc_valid_in && !full_out;
  assign commit_fire         = busy_q[head_q] && done_q[head_q];
  assign wb_hit              = wb_valid_in && (wb_rob_index_in <= LAST_IDX) && busy_q[wb_rob_index_in];

  // Returns {valid, value}; a same-cycle writeback is forwarded ahead of storage.
  function automatic logic [VAL_W:0] lookup(input logic [IDX_W-1:0] idx);
    logic [VAL_W:0] r;
    if (!((idx <= LAST_IDX) && busy_q[idx])) begin
      r = '0;
    end else if (wb_valid_in && (wb_rob_index_in == idx)) begin
      r = {1'b1, wb_value_in};
    end else begin
      r = {done_q[idx], VAL_W'(entry_q[idx].value)};
    end
    return r;
  endfunction

  always_comb begin
    {lookup_a_valid_out, lookup_a_value_out} = lookup(lookup_a_idx_in);
    {lookup_b_valid_out, lookup_b_value_out} = lookup(lookup_b_idx_in);
  end

  always_comb begin
    entry_d        = entry_q;
    busy_d         = busy_q;
    done_d         = done_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    commit_d       = commit_q;
    commit_idx_d   = commit_idx_q;
    commit_valid_d = commit_fire;

    if (commit_fire) begin
      commit_d         = entry_q[head_q];
      commit_idx_d     = head_q;
      busy_d[head_q]   = 1'b0;
      done_d[head_q]   = 1'b0;
      head_d           = head_next;
    end

    if (wb_hit) begin
      entry_d[wb_rob_index_in].value = GPR_BITS'(wb_value_in);
      entry_d[wb_rob_index_in].nzcv  = wb_nzcv_in;
      done_d[wb_rob_index_in]        = busy_d[wb_rob_index_in];
    end

    if (alloc_ok) begin
      entry_d[tail_q] = '{gpr_index:  alloc_gpr_index_in,
                          writes_gpr: alloc_writes_gpr_in,
                          set_nzcv:   alloc_set_nzcv_in,
                          value:      '0,
                          nzcv:       '0};
      busy_d[tail_q]  = 1'b1;
      done_d[tail_q]  = 1'b0;
      tail_d          = tail_next;
    end

    if (alloc_ok && !commit_fire) begin
      count_d = count_q + CNT_W'(1);
    end else if (!alloc_ok && commit_fire) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || flush_in) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      busy_q         <= '0;
      done_q         <= '0;
      commit_valid_q <= 1'b0;
      commit_q       <= '0;
      commit_idx_q   <= '0;
    end else begin
      entry_q        <= entry_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      commit_valid_q <= commit_valid_d;
      commit_q       <= commit_d;
      commit_idx_q   <= commit_idx_d;
    end
  end

  assign commit_valid_out      = commit_valid_q;
  assign commit_gpr_index_out  = commit_q.gpr_index;
  assign commit_writes_gpr_out = commit_q.writes_gpr;
  assign commit_value_out      = VAL_W'(commit_q.value);
  assign commit_set_nzcv_out   = commit_q.set_nzcv;
  assign commit_nzcv_out       = commit_q.nzcv;
  assign commit_rob_index_out  = commit_idx_q;

endmodule

`default_nettype wire

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular reorder buffer for the Tomasulo core.
- Decode allocates one entry per dispatched instruction in program order. FU writeback (ALU/LS) fills results out of order.
- The head entry retires in order to the GPR file and NZCV register, at most one per cycle.
- Also serves operand lookups so dispatch can capture values already produced but not yet committed.

Parameters:
- ROB_SIZE, `ROB_SIZE (18), number of entries; not required to be a power of two.
- IDX_W, `ROB_IDX_SIZE (5), entry index width.
- VAL_W, `GPR_SIZE (64), result value width.

Ports:
- clk_in  in  1  clock; all state updates on rising edge.
- rst_in  in  1  synchronous active-high reset.
- flush_in  in  1  mispredict flush; discard all entries.
- alloc_valid_in  in  1  decode requests an entry this cycle.
- alloc_gpr_index_in  in  `GPR_IDX_SIZE  destination GPR.
- alloc_writes_gpr_in  in  1  instruction writes a GPR.
- alloc_set_nzcv_in  in  1  instruction sets flags.
- alloc_rob_index_out  out  IDX_W  index the request receives (current tail); combinational.
- full_out  out  1  count == ROB_SIZE; combinational.
- wb_valid_in  in  1  FU result broadcast.
- wb_rob_index_in  in  IDX_W  target entry.
- wb_value_in  in  VAL_W  result.
- wb_nzcv_in  in  `NZCV_SIZE  flags result (nzcv_t).
- lookup_a_idx_in, lookup_b_idx_in  in  IDX_W  operand lookup indices.
- lookup_a_valid_out, lookup_b_valid_out  out  1  entry holds its value; combinational.
- lookup_a_value_out, lookup_b_value_out  out  VAL_W  entry value; combinational.
- commit_valid_out  out  1  one-cycle retire pulse.
- commit_gpr_index_out  out  `GPR_IDX_SIZE  retiring destination.
- commit_writes_gpr_out  out  1  regfile write enable qualifier.
- commit_value_out  out  VAL_W  retiring value.
- commit_set_nzcv_out  out  1  flags write enable qualifier.
- commit_nzcv_out  out  `NZCV_SIZE  retiring flags.
- commit_rob_index_out  out  IDX_W  retiring index, so the GPR table can clear the matching rename tag.

Behaviour:
- State:
  - head, tail: IDX_W each.
  - count: 0..ROB_SIZE.
  - Per entry: busy, done, rob_entry_t fields, plus writes_gpr.
- Reset (rst_in high at an edge): head = tail = count = 0; all busy/done cleared; every commit_* output 0. Reset mid-operation discards all in-flight entries.
- Pointer arithmetic: increment wraps from ROB_SIZE-1 to 0 (explicit compare, not bit truncation).
- Allocation: when alloc_valid_in && !full_out, the tail entry gets busy=1, done=0 and the fields are written; tail advances.
- Full: full_out uses pre-edge count, so alloc is refused when full even if a commit occurs the same cycle. A refused alloc leaves all state unchanged; decode must hold its request.
- Writeback: when wb_valid_in and the target is busy, store value and nzcv and set done=1. Writeback to a non-busy entry is ignored.
- Commit: at an edge where the head is busy && done, register its fields into commit_*, set commit_valid_out=1, clear busy, advance head. Otherwise commit_valid_out=0 next cycle.
- Commit latency: a writeback at edge t is visible as done after t. It can commit at edge t+1, so commit_valid_out is high during cycle t+1..t+2. No same-edge writeback-to-commit bypass.
- Count: count += alloc_accepted - commit_fired. Simultaneous alloc and commit leave count unchanged.
- Lookup: valid = busy && (done || (wb_valid_in && wb_rob_index_in == idx)). On a same-cycle writeback match, value is forwarded from wb_value_in; otherwise it is the stored value. Non-busy index returns valid=0, value 0.
- Flush: flush_in has priority over alloc, writeback and commit. Its effect equals reset except that it is driven by a separate port. commit_valid_out=0 in the following cycle.
- Empty: count==0; no commit; alloc_rob_index_out = tail.

Decomposition:
- Shared package (data_structures): `ROB_SIZE, `ROB_IDX_SIZE, rob_entry_t, nzcv_t.
- Add a writes_gpr bit to rob_entry_t instead of a local side array.
- Sub-module rob_ptr_inc: modular increment for a non-power-of-two size; reused by the RS free list.

Test Plan:
- Reset, then alloc 3 entries (gpr 1,2,3) -> indices 0,1,2; count 3. Writeback idx1=0x22 then idx0=0x11 -> commits in order: gpr1=0x11, then gpr2=0x22; idx2 does not commit until written.
- Alloc 18 entries -> full_out=1. A 19th alloc is refused with tail unchanged. Commit one, then alloc -> index 0 reused after head passes 0. Tail wraps 17->0.
- Writeback idx4=0xDEAD with lookup_a_idx=4 in the same cycle -> lookup_a_valid=1, value 0xDEAD (forward); next cycle same result from storage.
- Full buffer with head done, alloc and commit the same cycle -> commit fires, alloc refused, count goes 18->17.
- Flush with 5 entries, 2 done -> next cycle count 0, commit_valid 0, alloc returns index 0; a later writeback to idx 3 is ignored.
- Entry with alloc_set_nzcv=1, wb nzcv=4'b0100 -> commit_set_nzcv=1, commit_nzcv=4'b0100, commit_writes_gpr as allocated.
